// File: rtl/binary_test_stream.sv
// ---------------------------------------------------------------------------
// binary_test_stream
//   Streaming binary intensity test. Each accepted input beat carries PAIRS
//   pixel pairs. Every pair is compared to give one descriptor bit. The bits
//   of consecutive beats are packed MSB-first into a DESC_BITS-wide
//   descriptor, which is then held on an output valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    input beat valid
//   in_ready    block accepts a beat (high only while accumulating)
//   in_x        pair i x-value at [i*PIX_W +: PIX_W]
//   in_y        pair i y-value, same packing
//   in_last     beat is the last one of the descriptor
//   cfg_mode    0: bit = x < y ; 1: bit = (x + cfg_thr) < y
//   cfg_thr     threshold used when cfg_mode = 1
//   desc_valid  descriptor available
//   desc_ready  consumer accepts the descriptor
//   desc_data   packed descriptor (pair 0 of beat 0 in the MSB)
//   desc_err    descriptor length error (early in_last, or in_last missing)
// ---------------------------------------------------------------------------
module binary_test_stream #(
  parameter int PIX_W     = 8,
  parameter int PAIRS     = 8,
  parameter int DESC_BITS = 256,
  parameter int THR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAIRS*PIX_W-1:0] in_x,
  input  logic [PAIRS*PIX_W-1:0] in_y,
  input  logic                   in_last,
  input  logic                   cfg_mode,
  input  logic [THR_W-1:0]       cfg_thr,
  output logic                   desc_valid,
  input  logic                   desc_ready,
  output logic [DESC_BITS-1:0]   desc_data,
  output logic                   desc_err
);

  localparam int BEATS = DESC_BITS / PAIRS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // One extra bit so x + thr can never wrap around.
  localparam int SUM_W = ((PIX_W > THR_W) ? PIX_W : THR_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Single pair comparison, unsigned, in a widened domain.
  function automatic logic pair_bit(
    input logic [PIX_W-1:0] x,
    input logic [PIX_W-1:0] y,
    input logic             mode,
    input logic [THR_W-1:0] thr
  );
    logic [SUM_W-1:0] lhs;
    logic [SUM_W-1:0] rhs;
    lhs = SUM_W'(x) + (mode ? SUM_W'(thr) : {SUM_W{1'b0}});
    rhs = SUM_W'(y);
    return (lhs < rhs);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DESC_BITS-1:0] acc_q, acc_d;
  logic [DESC_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [PAIRS-1:0]     beat_bits_s;
  logic [DESC_BITS-1:0] placed_s;
  logic                 accept_s;
  logic                 at_end_s;

  // Compare all pairs of the current beat; pair 0 lands in the top bit.
  always_comb begin
    beat_bits_s = '0;
    for (int i = 0; i < PAIRS; i++) begin
      beat_bits_s[PAIRS-1-i] = pair_bit(in_x[i*PIX_W +: PIX_W],
                                        in_y[i*PIX_W +: PIX_W],
                                        cfg_mode, cfg_thr);
    end
  end

  // Position the beat's bits at their final descriptor slot, so an early
  // close leaves the filled bits MSB-aligned and the remainder zero.
  always_comb begin
    placed_s = DESC_BITS'(beat_bits_s) << (PAIRS * (BEATS - 1 - int'(cnt_q)));
  end

  assign accept_s = in_valid && in_ready_q;
  assign at_end_s = (cnt_q == LAST_CNT);

  // Next-state and output-register logic for the ACCUM/HOLD controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    data_d     = data_q;
    err_d      = err_q;
    valid_d    = valid_q;
    in_ready_d = in_ready_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = acc_q | placed_s;
          if (in_last || at_end_s) begin
            // Only an in_last on exactly the final beat is a clean close.
            state_d    = ST_HOLD;
            data_d     = acc_q | placed_s;
            err_d      = !(in_last && at_end_s);
            valid_d    = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (desc_ready) begin
          state_d    = ST_ACCUM;
          valid_d    = 1'b0;
          cnt_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_ACCUM;
        valid_d    = 1'b0;
        cnt_d      = '0;
        acc_d      = '0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign desc_valid = valid_q;
  assign desc_data  = data_q;
  assign desc_err   = err_q;

endmodule

// File: tb/tb_binary_test_stream.sv
module tb_binary_test_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_x;
  logic [63:0]  in_y;
  logic         in_last;
  logic         cfg_mode;
  logic [7:0]   cfg_thr;
  logic         desc_valid;
  logic         desc_ready;
  logic [255:0] desc_data;
  logic         desc_err;

  int checks   = 0;
  int errors   = 0;
  int timeouts = 0;

  logic [63:0]  bx [32];
  logic [63:0]  by [32];
  logic         bm [32];
  logic [7:0]   bt [32];
  logic [255:0] exp_desc;
  logic         exp_err;
  logic [255:0] held;

  always #5 clk = ~clk;

  binary_test_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_last    (in_last),
    .cfg_mode   (cfg_mode),
    .cfg_thr    (cfg_thr),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_data  (desc_data),
    .desc_err   (desc_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic model_bit(input int x, input int y, input int m, input int t);
    if (m != 0) return ((x + t) < y);
    else        return (x < y);
  endfunction

  function automatic logic [7:0] beat_bits(input int b);
    logic [7:0] r;
    r = 8'h00;
    for (int p = 0; p < 8; p++)
      r[7-p] = model_bit(int'(bx[b][p*8 +: 8]), int'(by[b][p*8 +: 8]), int'(bm[b]), int'(bt[b]));
    return r;
  endfunction

  task automatic fill_random();
    for (int b = 0; b < 32; b++) begin
      bx[b] = {$urandom, $urandom};
      by[b] = {$urandom, $urandom};
      bm[b] = 1'($urandom_range(0, 1));
      bt[b] = 8'($urandom_range(0, 63));
    end
  endtask

  task automatic fill_const(input logic [7:0] x, input logic [7:0] y);
    for (int b = 0; b < 32; b++) begin
      bx[b] = {8{x}};
      by[b] = {8{y}};
      bm[b] = 1'b0;
      bt[b] = 8'h00;
    end
  endtask

  task automatic drive_beat(input int b, input logic last);
    in_valid = 1'b1;
    in_x     = bx[b];
    in_y     = by[b];
    cfg_mode = bm[b];
    cfg_thr  = bt[b];
    in_last  = last;
  endtask

  task automatic send_beat(input int b, input logic last, input bit gap);
    logic acc;
    bit   ok;
    if (gap) repeat ($urandom_range(0, 2)) tick();
    drive_beat(b, last);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic run_desc(input int n, input bit use_last, input bit gap);
    exp_desc = '0;
    for (int b = 0; b < n; b++) begin
      if (b == n - 1) chk("valid_before_close", 256'(desc_valid), 256'(0));
      send_beat(b, use_last && (b == n - 1), gap);
      exp_desc[255 - 8*b -: 8] = beat_bits(b);
    end
    exp_err = !(use_last && (n == 32));
    chk("valid_latency", 256'(desc_valid), 256'(1));
  endtask

  task automatic take_desc(input bit rnd, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      desc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (desc_valid && desc_ready) begin
        chk({tag, "_data"}, desc_data, exp_desc);
        chk({tag, "_err"}, 256'(desc_err), 256'(exp_err));
        ok = 1'b1;
      end
      tick();
      if (ok) break;
    end
    desc_ready = 1'b0;
    if (!ok) timeouts++;
    else chk({tag, "_valid_drop"}, 256'(desc_valid), 256'(0));
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    in_last    = 1'b0;
    cfg_mode   = 1'b0;
    cfg_thr    = 8'h00;
    desc_ready = 1'b0;
    tick();
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_desc_valid", 256'(desc_valid), 256'(0));
    chk("rst_desc_data", desc_data, 256'(0));
    chk("rst_desc_err", 256'(desc_err), 256'(0));
    rst = 1'b0;
    tick();

    // Full descriptor, x=i, y=i+1 on every pair -> all ones, clean close.
    for (int b = 0; b < 32; b++) begin
      bx[b] = {8{8'(b)}};
      by[b] = {8{8'(b + 1)}};
      bm[b] = 1'b0;
      bt[b] = 8'h00;
    end
    run_desc(32, 1'b1, 1'b0);
    chk("t1_in_ready_hold", 256'(in_ready), 256'(0));
    chk("t1_all_ones", desc_data, {256{1'b1}});
    take_desc(1'b0, "t1");
    chk("t1_data_kept", desc_data, {256{1'b1}});
    chk("t1_in_ready_back", 256'(in_ready), 256'(1));

    // Threshold mode and no-wrap corner cases, early in_last on beat 2.
    bx[0] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd10, 8'd10};
    by[0] = {8'd200, 8'd200, 8'd200, 8'd200, 8'd0, 8'd255, 8'd16, 8'd15};
    bm[0] = 1'b1;
    bt[0] = 8'd5;
    bx[1] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    by[1] = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
    bm[1] = 1'b1;
    bt[1] = 8'd255;
    bx[2] = {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2};
    by[2] = {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    bm[2] = 1'b0;
    bt[2] = 8'd0;
    run_desc(3, 1'b1, 1'b0);
    chk("t2_hand_bits", desc_data, {24'h4F0080, 232'd0});
    take_desc(1'b0, "t2");

    // Early in_last on beat 2 with all-ones beats.
    fill_const(8'd0, 8'd1);
    run_desc(3, 1'b1, 1'b0);
    chk("t3_hand_bits", desc_data, {24'hFFFFFF, 232'd0});
    chk("t3_hand_err", 256'(desc_err), 256'(1));
    take_desc(1'b0, "t3");

    // 32 beats with no in_last: closes with error.
    fill_random();
    run_desc(32, 1'b0, 1'b0);
    chk("t4_hand_err", 256'(desc_err), 256'(1));
    held = desc_data;
    // Next beat is offered while the consumer stalls for 10 cycles.
    bx[0] = {$urandom, $urandom};
    by[0] = {$urandom, $urandom};
    bm[0] = 1'b0;
    drive_beat(0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_stable", desc_data, held);
      chk("t5_in_ready", 256'(in_ready), 256'(0));
    end
    take_desc(1'b0, "t4");
    send_beat(0, 1'b1, 1'b0);
    chk("t5_valid", 256'(desc_valid), 256'(1));
    exp_desc = '0;
    exp_desc[255 -: 8] = beat_bits(0);
    exp_err = 1'b1;
    take_desc(1'b0, "t5");

    // Reset in the middle of beat 15.
    fill_random();
    for (int b = 0; b < 15; b++) send_beat(b, 1'b0, 1'b0);
    drive_beat(15, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", 256'(in_ready), 256'(1));
    chk("t6_rst_valid", 256'(desc_valid), 256'(0));
    chk("t6_rst_data", desc_data, 256'(0));
    chk("t6_rst_err", 256'(desc_err), 256'(0));
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    fill_const(8'd5, 8'd5);
    run_desc(32, 1'b1, 1'b0);
    take_desc(1'b0, "t6");

    // Random traffic with random stalls.
    for (int d = 0; d < 100; d++) begin
      int  n;
      bit  use_last;
      fill_random();
      use_last = ($urandom_range(0, 3) != 0);
      n = use_last ? $urandom_range(1, 32) : 32;
      run_desc(n, use_last, 1'b1);
      take_desc(1'b1, "rnd");
    end

    chk("accept_timeouts", 256'(timeouts), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
